// File: rtl/aes_key_pkg.sv
// Shared constants, FSM state type and GF(2^8) helper for the AES-128 key expander.
package aes_key_pkg;
  localparam int NK = 4;
  localparam int NR = 10;
  localparam int NW = NK * (NR + 1);
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SUB0,
    ST_SUB1,
    ST_SUB2,
    ST_PLAIN,
    ST_DONE
  } state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction
endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: loads 0x01 at key acceptance and steps by xtime once per round.
module aes_rcon_gen
  import aes_key_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic       step_i,
  output logic [7:0] rcon_o
);
  logic [7:0] rcon_q, rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (load_i)      rcon_d = RCON_INIT;
    else if (step_i) rcon_d = xtime(rcon_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rcon_q <= '0;
    else          rcon_q <= rcon_d;
  end

  assign rcon_o = rcon_q;
endmodule

// File: rtl/aes128_key_expander.sv
// AES-128 key schedule sequencer: streams w0..w43 into the round-key store, using an
// external two-port registered S-box ROM for SubWord.
module aes128_key_expander
  import aes_key_pkg::*;
#(
  parameter int RK_ADDR_BITS = 6,
  parameter int RK_BASE      = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [127:0]            key_in,
  output logic                    busy,
  output logic                    done,
  output logic                    sbox_enA,
  output logic [7:0]              sbox_addrA,
  input  logic [7:0]              sbox_dataA,
  output logic                    sbox_enB,
  output logic [7:0]              sbox_addrB,
  input  logic [7:0]              sbox_dataB,
  output logic                    rk_we,
  output logic [RK_ADDR_BITS-1:0] rk_addr,
  output logic [31:0]             rk_data
);
  localparam logic [5:0] LAST_IDX = 6'(NW - 1);

  state_e            state_q, state_d;
  logic [3:0][31:0]  win_q, win_d;
  logic [5:0]        idx_q, idx_d;
  logic [15:0]       sub_hi_q, sub_hi_d;
  logic [7:0]        rcon;
  logic [31:0]       rot;
  logic [31:0]       word;
  logic              accept;
  logic              wr;

  assign accept = (state_q == ST_IDLE) && start;
  assign rot    = {win_q[3][23:0], win_q[3][31:24]};
  assign wr     = (state_q == ST_LOAD) || (state_q == ST_SUB2) || (state_q == ST_PLAIN);

  aes_rcon_gen u_rcon (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (accept),
    .step_i  (state_q == ST_SUB2),
    .rcon_o  (rcon)
  );

  // Key words are emitted by rotating the window, so after LOAD it again holds w0..w3.
  always_comb begin
    word = '0;
    unique case (state_q)
      ST_LOAD:  word = win_q[0];
      ST_SUB2:  word = win_q[0] ^ {sub_hi_q, sbox_dataA, sbox_dataB} ^ {rcon, 24'h0};
      ST_PLAIN: word = win_q[0] ^ win_q[3];
      default:  word = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  if (idx_q[1:0] == 2'd3) state_d = ST_SUB0;
      ST_SUB0:  state_d = ST_SUB1;
      ST_SUB1:  state_d = ST_SUB2;
      ST_SUB2:  state_d = ST_PLAIN;
      ST_PLAIN: begin
        if (idx_q == LAST_IDX)        state_d = ST_DONE;
        else if (idx_q[1:0] == 2'd3)  state_d = ST_SUB0;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    win_d    = win_q;
    idx_d    = idx_q;
    sub_hi_d = sub_hi_q;
    if (accept) begin
      win_d = {key_in[31:0], key_in[63:32], key_in[95:64], key_in[127:96]};
      idx_d = '0;
    end else if (wr) begin
      win_d = {word, win_q[3], win_q[2], win_q[1]};
      idx_d = idx_q + 6'd1;
    end
    if (state_q == ST_SUB1) sub_hi_d = {sbox_dataA, sbox_dataB};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      idx_q    <= '0;
      sub_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      idx_q    <= idx_d;
      sub_hi_q <= sub_hi_d;
    end
  end

  // SUB0 looks up the upper half of RotWord, SUB1 the lower half.
  always_comb begin
    sbox_enA   = 1'b0;
    sbox_enB   = 1'b0;
    sbox_addrA = '0;
    sbox_addrB = '0;
    if (state_q == ST_SUB0) begin
      sbox_enA   = 1'b1;
      sbox_enB   = 1'b1;
      sbox_addrA = rot[31:24];
      sbox_addrB = rot[23:16];
    end else if (state_q == ST_SUB1) begin
      sbox_enA   = 1'b1;
      sbox_enB   = 1'b1;
      sbox_addrA = rot[15:8];
      sbox_addrB = rot[7:0];
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign rk_we   = wr;
  assign rk_data = word;
  assign rk_addr = wr ? (RK_ADDR_BITS'(RK_BASE) + RK_ADDR_BITS'(idx_q)) : '0;
endmodule
